road_shift_out: RTL and testbench
=================================

ROAD_SHIFT_OUT -- requirements
Module: road_shift_out

Interface
REQ-001 Parameter N_CELLS, default 20, number of road cells per frame (cell 1..N_CELLS).
REQ-002 Parameter CLK_DIV, default 4, i_clk cycles per o_sclk half-period; legal range 1..255.
REQ-003 i_clk  input  1  single clock, all logic rising-edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_cells  input  N_CELLS  occupancy snapshot from the traffic simulator; bit k = cell k+1.
REQ-006 i_valid  input  1  one-cycle strobe: i_cells holds a new frame.
REQ-007 o_sclk  output  1  shift clock to external 74HC595 chain.
REQ-008 o_sdata  output  1  serial data, stable around every o_sclk rising edge.
REQ-009 o_latch  output  1  storage-register latch pulse to the chain.
REQ-010 o_busy  output  1  high while a frame is being shifted or latched.
REQ-011 o_overrun  output  1  one-cycle pulse when a pending frame is overwritten.
REQ-012 o_frame_cnt  output  8  count of completed (latched) frames.

Function
REQ-013 States SHALL be IDLE, SHIFT, LATCH; the reset state is IDLE.
REQ-014 In IDLE, i_valid=1 SHALL capture i_cells into the shift buffer and enter SHIFT on the next cycle.
REQ-015 SHIFT SHALL send bit N_CELLS-1 first and bit 0 last, one bit per o_sclk period.
REQ-016 Each bit: o_sdata is updated on entry to the low phase; o_sclk low CLK_DIV cycles, then high CLK_DIV cycles.
REQ-017 After the last high phase, the block SHALL enter LATCH: o_sclk=0 and o_latch=1 for CLK_DIV cycles.
REQ-018 The frame SHALL occupy exactly 2*N_CELLS*CLK_DIV + CLK_DIV cycles from the first SHIFT cycle; default 164.
REQ-019 o_busy SHALL be 1 in SHIFT and LATCH and 0 in IDLE.
REQ-020 i_valid during SHIFT or LATCH SHALL store i_cells in a one-deep pending buffer and set pending; the in-flight frame is unaffected.
REQ-021 i_valid while pending is already set SHALL overwrite the buffer (newest wins) and pulse o_overrun for one cycle.
REQ-022 On the last LATCH cycle with pending set, the block SHALL load the pending buffer, clear pending, and enter SHIFT next cycle without any IDLE cycle.
REQ-023 i_valid on the last LATCH cycle with pending clear SHALL be treated as pending and start on the next cycle as in REQ-022.
REQ-024 o_frame_cnt SHALL increment on the last LATCH cycle and wrap 255 -> 0.
REQ-025 In IDLE, o_sclk=0, o_latch=0 and o_sdata SHALL hold its last value.

Reset
REQ-026 On i_rst_n=0: state IDLE; o_sclk, o_sdata, o_latch, o_busy, o_overrun = 0; o_frame_cnt = 0; pending clear; buffers zeroed.
REQ-027 Reset mid-frame SHALL abort without producing an o_latch pulse; no partial frame is latched.
REQ-028 After release of reset, the first i_valid is accepted only if sampled at or after the first rising edge with i_rst_n=1.

Structure
REQ-029 N_CELLS default and the CLK_DIV default SHALL live in shared package road_pkg, together with the simulator's road length, so both stages agree.
REQ-030 The o_sclk phase timing SHALL be a sub-module, sclk_tick_gen: a down-counter producing a one-cycle phase-end tick every CLK_DIV cycles, enabled only outside IDLE.
REQ-031 The shift buffer, pending buffer, bit index and FSM SHALL remain in road_shift_out.

Verification
REQ-032 Defaults; i_cells=20'h80001, one i_valid -> 20 o_sclk rising edges, sampled bits 1,0x18,1; one o_latch of 4 cycles; o_busy high 164 cycles; o_frame_cnt=1.
REQ-033 CLK_DIV=1, i_cells=20'hAAAAA -> alternating 1,0 on 20 edges, frame 41 cycles.
REQ-034 i_valid with 20'h00001 during SHIFT of frame A -> frame A completes; frame B starts the cycle after A's last LATCH cycle; o_overrun never pulses.
REQ-035 Three i_valid strobes (B, C, D) during frame A -> o_overrun pulses twice; frames A then D shifted; o_frame_cnt=2.
REQ-036 i_rst_n low on cycle 50 of a frame -> all outputs 0 within the same cycle; no o_latch; o_frame_cnt=0; next i_valid shifts cleanly.
REQ-037 256 back-to-back frames -> o_frame_cnt wraps to 0.

Source files
------------

// File: rtl/road_pkg.sv
// ---------------------------------------------------------------------------
// road_pkg
// Shared constants for the road traffic simulator and its LED shift-out
// stage. The simulator and the shift-out stage both import this package, so
// they always agree on the road length and the shift clock divider.
// Contents:
//   ROAD_LEN     - number of road cells modelled by the traffic simulator
//   N_CELLS_DEF  - default frame width for road_shift_out (one bit per cell)
//   CLK_DIV_DEF  - default i_clk cycles per o_sclk half-period
//   shiftState_t - FSM states of road_shift_out
// ---------------------------------------------------------------------------
package road_pkg;

    localparam int ROAD_LEN    = 20;
    localparam int N_CELLS_DEF = ROAD_LEN;
    localparam int CLK_DIV_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } shiftState_t;

endpackage

// File: rtl/road_shift_out_sclk_tick_gen.sv
// ---------------------------------------------------------------------------
// sclk_tick_gen
// Phase timer for the serial shift clock. A down-counter that produces a
// one-cycle tick at the end of every CLK_DIV-cycle phase while enabled.
// When disabled the counter is parked at CLK_DIV-1, so the first tick after
// enabling always lands exactly CLK_DIV cycles later.
// Ports:
//   i_clk    - system clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_en     - count enable (high whenever the shifter is not idle)
//   o_tick   - one-cycle pulse on the last cycle of each phase
// ---------------------------------------------------------------------------
import road_pkg::*;

module sclk_tick_gen #(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] r_count;

    // Reload on phase end and while disabled so that phases stay aligned
    // across back-to-back frames and restart cleanly out of idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= RELOAD;
        end else if (!i_en || (r_count == 8'd0)) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_tick = i_en && (r_count == 8'd0);

endmodule

// File: rtl/road_shift_out.sv
// ---------------------------------------------------------------------------
// road_shift_out
// Serialises road-occupancy frames into an external 74HC595 chain. Each
// frame is shifted MSB (cell N_CELLS) first, one bit per o_sclk period, then
// latched into the storage registers. A one-deep pending buffer lets the
// simulator post the next frame while the current one is still in flight;
// a pending frame is started directly after the latch with no idle gap.
// Ports:
//   i_clk        - system clock, rising edge
//   i_rst_n      - asynchronous active-low reset
//   i_cells      - occupancy snapshot, bit k = cell k+1
//   i_valid      - one-cycle strobe, i_cells holds a new frame
//   o_sclk       - shift clock to the chain
//   o_sdata      - serial data, changes only at the start of a low phase
//   o_latch      - storage-register latch pulse (CLK_DIV cycles)
//   o_busy       - high while shifting or latching
//   o_overrun    - one-cycle pulse when a pending frame is overwritten
//   o_frame_cnt  - number of completed frames, wraps at 256
// ---------------------------------------------------------------------------
import road_pkg::*;

module road_shift_out #(
    parameter int N_CELLS = N_CELLS_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_CELLS-1:0] i_cells,
    input  logic               i_valid,
    output logic               o_sclk,
    output logic               o_sdata,
    output logic               o_latch,
    output logic               o_busy,
    output logic               o_overrun,
    output logic [7:0]         o_frame_cnt
);

    localparam int IDXW = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

    shiftState_t        r_state;
    shiftState_t        w_nextState;
    logic [N_CELLS-1:0] r_shiftBuf;
    logic [N_CELLS-1:0] r_pendBuf;
    logic               r_pending;
    logic [IDXW-1:0]    r_bitIdx;
    logic               r_phaseHigh;
    logic               r_sdata;
    logic               r_overrun;
    logic [7:0]         r_frameCnt;

    logic               w_tickEn;
    logic               w_tick;
    logic               w_lastBit;
    logic               w_frameDone;
    logic               w_startNext;
    logic               w_load;
    logic [N_CELLS-1:0] w_loadData;

    assign w_tickEn = (r_state != IDLE);

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclkTickGen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_tickEn),
        .o_tick  (w_tick)
    );

    // End of the high phase of bit 0 closes the shift part of the frame;
    // end of the latch phase closes the whole frame.
    assign w_lastBit   = (r_state == SHIFT) && w_tick && r_phaseHigh && (r_bitIdx == '0);
    assign w_frameDone = (r_state == LATCH) && w_tick;

    // A strobe on the very last latch cycle counts as pending, so the next
    // frame follows immediately whether it was queued earlier or just now.
    assign w_startNext = w_frameDone && (r_pending || i_valid);
    assign w_load      = ((r_state == IDLE) && i_valid) || w_startNext;
    assign w_loadData  = ((r_state != IDLE) && r_pending) ? r_pendBuf : i_cells;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (i_valid) w_nextState = SHIFT;
            SHIFT:   if (w_lastBit) w_nextState = LATCH;
            LATCH:   if (w_frameDone) w_nextState = w_startNext ? SHIFT : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Shift datapath. Loading a frame presents its MSB straight away, so the
    // first low phase already carries valid data; later bits are presented
    // when a high phase ends, giving CLK_DIV cycles of setup before each rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shiftBuf  <= '0;
            r_bitIdx    <= '0;
            r_phaseHigh <= 1'b0;
            r_sdata     <= 1'b0;
        end else if (w_load) begin
            r_shiftBuf  <= w_loadData;
            r_bitIdx    <= IDXW'(N_CELLS - 1);
            r_phaseHigh <= 1'b0;
            r_sdata     <= w_loadData[N_CELLS-1];
        end else if ((r_state == SHIFT) && w_tick) begin
            if (!r_phaseHigh) begin
                r_phaseHigh <= 1'b1;
            end else begin
                r_phaseHigh <= 1'b0;
                if (r_bitIdx != '0) begin
                    r_bitIdx <= r_bitIdx - 1'b1;
                    r_sdata  <= r_shiftBuf[r_bitIdx - 1'b1];
                end
            end
        end
    end

    // Pending buffer. A strobe while busy is queued, except on the last latch
    // cycle with nothing queued, where it is loaded directly instead. When the
    // queued frame is consumed in the same cycle as a new strobe, the strobe
    // simply takes its place and is not an overrun.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pendBuf <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_valid && (r_state != IDLE) && !(w_startNext && !r_pending)) begin
                r_pendBuf <= i_cells;
                r_pending <= 1'b1;
                r_overrun <= r_pending && !w_startNext;
            end else if (w_startNext) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Completed-frame counter, wraps naturally at 8 bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frameCnt <= 8'd0;
        end else if (w_frameDone) begin
            r_frameCnt <= r_frameCnt + 8'd1;
        end
    end

    assign o_sclk      = (r_state == SHIFT) && r_phaseHigh;
    assign o_sdata     = r_sdata;
    assign o_latch     = (r_state == LATCH);
    assign o_busy      = (r_state != IDLE);
    assign o_overrun   = r_overrun;
    assign o_frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_road_shift_out.sv
// ---------------------------------------------------------------------------
// tb_road_shift_out
// Directed bench for road_shift_out. dut0 runs with the default parameters
// (20 cells, CLK_DIV=4), dut1 with CLK_DIV=1. A monitor per DUT samples on
// the falling clock edge and accumulates sclk rises, captured serial bits,
// latch/busy/overrun activity and data-stability violations; each test takes
// a snapshot first and compares the deltas against hand-computed values.
// ---------------------------------------------------------------------------
module tb_road_shift_out;

    logic        clk;
    logic        rstN0, rstN1;
    logic [19:0] cells0, cells1;
    logic        valid0, valid1;
    logic        sclk0, sdata0, latch0, busy0, overrun0;
    logic        sclk1, sdata1, latch1, busy1, overrun1;
    logic [7:0]  frameCnt0, frameCnt1;

    int testsRun    = 0;
    int testsFailed = 0;

    road_shift_out dut0 (
        .i_clk       (clk),
        .i_rst_n     (rstN0),
        .i_cells     (cells0),
        .i_valid     (valid0),
        .o_sclk      (sclk0),
        .o_sdata     (sdata0),
        .o_latch     (latch0),
        .o_busy      (busy0),
        .o_overrun   (overrun0),
        .o_frame_cnt (frameCnt0)
    );

    road_shift_out #(.N_CELLS(20), .CLK_DIV(1)) dut1 (
        .i_clk       (clk),
        .i_rst_n     (rstN1),
        .i_cells     (cells1),
        .i_valid     (valid1),
        .o_sclk      (sclk1),
        .o_sdata     (sdata1),
        .o_latch     (latch1),
        .o_busy      (busy1),
        .o_overrun   (overrun1),
        .o_frame_cnt (frameCnt1)
    );

    // 10 ns system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running activity counters for dut0.
    int          edges0 = 0, latchPulses0 = 0, latchCyc0 = 0, busyCyc0 = 0;
    int          busyFalls0 = 0, ovCyc0 = 0, stabErr0 = 0;
    logic [63:0] bits0 = '0;
    logic        pSclk0 = 0, pSdata0 = 0, pLatch0 = 0, pBusy0 = 0;

    always @(negedge clk) begin
        if (sclk0 && !pSclk0) begin
            edges0 = edges0 + 1;
            bits0  = {bits0[62:0], sdata0};
        end
        if (sclk0 && (sdata0 != pSdata0)) stabErr0 = stabErr0 + 1;
        if (latch0) latchCyc0 = latchCyc0 + 1;
        if (latch0 && !pLatch0) latchPulses0 = latchPulses0 + 1;
        if (busy0) busyCyc0 = busyCyc0 + 1;
        if (!busy0 && pBusy0) busyFalls0 = busyFalls0 + 1;
        if (overrun0) ovCyc0 = ovCyc0 + 1;
        pSclk0  = sclk0;
        pSdata0 = sdata0;
        pLatch0 = latch0;
        pBusy0  = busy0;
    end

    // Running activity counters for dut1.
    int          edges1 = 0, latchPulses1 = 0, latchCyc1 = 0, busyCyc1 = 0;
    int          busyFalls1 = 0, ovCyc1 = 0, stabErr1 = 0;
    logic [63:0] bits1 = '0;
    logic        pSclk1 = 0, pSdata1 = 0, pLatch1 = 0, pBusy1 = 0;

    always @(negedge clk) begin
        if (sclk1 && !pSclk1) begin
            edges1 = edges1 + 1;
            bits1  = {bits1[62:0], sdata1};
        end
        if (sclk1 && (sdata1 != pSdata1)) stabErr1 = stabErr1 + 1;
        if (latch1) latchCyc1 = latchCyc1 + 1;
        if (latch1 && !pLatch1) latchPulses1 = latchPulses1 + 1;
        if (busy1) busyCyc1 = busyCyc1 + 1;
        if (!busy1 && pBusy1) busyFalls1 = busyFalls1 + 1;
        if (overrun1) ovCyc1 = ovCyc1 + 1;
        pSclk1  = sclk1;
        pSdata1 = sdata1;
        pLatch1 = latch1;
        pBusy1  = busy1;
    end

    int bEdges, bLp, bLc, bBc, bBf, bOv, bSe;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun = testsRun + 1;
        if (observed !== expected) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One-cycle i_valid strobe, driven just after a rising edge.
    task automatic applyStimulus(input int d, input logic [19:0] cells);
        @(posedge clk);
        #1;
        if (d == 0) begin cells0 = cells; valid0 = 1'b1; end
        else        begin cells1 = cells; valid1 = 1'b1; end
        @(posedge clk);
        #1;
        if (d == 0) valid0 = 1'b0;
        else        valid1 = 1'b0;
    endtask

    task automatic snap(input int d);
        bEdges = (d == 0) ? edges0       : edges1;
        bLp    = (d == 0) ? latchPulses0 : latchPulses1;
        bLc    = (d == 0) ? latchCyc0    : latchCyc1;
        bBc    = (d == 0) ? busyCyc0     : busyCyc1;
        bBf    = (d == 0) ? busyFalls0   : busyFalls1;
        bOv    = (d == 0) ? ovCyc0       : ovCyc1;
        bSe    = (d == 0) ? stabErr0     : stabErr1;
    endtask

    // Wait (bounded) for the DUT to return to idle, then settle past a posedge.
    task automatic waitIdle(input int d, input int maxCycles, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((d == 0) ? busy0 : busy1) && (n < maxCycles));
        checkOutput({tag, "_idle"}, 64'((d == 0) ? busy0 : busy1), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkFrame(input int d, input string tag, input int expEdges,
                              input int expLp, input int expLc, input int expBc,
                              input int expBf, input int expOv, input int nBits,
                              input logic [63:0] expBits);
        logic [63:0] mask;
        logic [63:0] b;
        mask = (nBits >= 64) ? '1 : ((64'd1 << nBits) - 64'd1);
        b    = (d == 0) ? bits0 : bits1;
        checkOutput({tag, "_sclkEdges"},   64'(((d == 0) ? edges0 : edges1) - bEdges), 64'(expEdges));
        checkOutput({tag, "_bits"},        b & mask, expBits);
        checkOutput({tag, "_latchPulses"}, 64'(((d == 0) ? latchPulses0 : latchPulses1) - bLp), 64'(expLp));
        checkOutput({tag, "_latchCycles"}, 64'(((d == 0) ? latchCyc0 : latchCyc1) - bLc), 64'(expLc));
        checkOutput({tag, "_busyCycles"},  64'(((d == 0) ? busyCyc0 : busyCyc1) - bBc), 64'(expBc));
        checkOutput({tag, "_busyFalls"},   64'(((d == 0) ? busyFalls0 : busyFalls1) - bBf), 64'(expBf));
        checkOutput({tag, "_overruns"},    64'(((d == 0) ? ovCyc0 : ovCyc1) - bOv), 64'(expOv));
        checkOutput({tag, "_sdataStable"}, 64'(((d == 0) ? stabErr0 : stabErr1) - bSe), 64'd0);
    endtask

    // dut1 only: wait for the single latch cycle and strobe during it.
    task automatic strobeAtLatch(input logic [19:0] cells);
        int n = 0;
        @(negedge clk);
        while (!latch1 && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        if (!latch1) checkOutput("t7_latchWait", 64'(latch1), 64'd1);
        cells1 = cells;
        valid1 = 1'b1;
        @(posedge clk);
        #1;
        valid1 = 1'b0;
    endtask

    logic [19:0] lastCells;

    initial begin
        rstN0  = 1'b0;
        rstN1  = 1'b0;
        cells0 = '0;
        cells1 = '0;
        valid0 = 1'b0;
        valid1 = 1'b0;

        // Reset state of both instances.
        #2;
        checkOutput("reset_outs0", {59'd0, sclk0, sdata0, latch0, busy0, overrun0}, 64'd0);
        checkOutput("reset_cnt0", 64'(frameCnt0), 64'd0);
        checkOutput("reset_outs1", {59'd0, sclk1, sdata1, latch1, busy1, overrun1}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rstN0 = 1'b1;
        rstN1 = 1'b1;
        @(posedge clk);
        #1;

        // Single default frame: 1, eighteen 0s, 1.
        snap(0);
        applyStimulus(0, 20'h80001);
        waitIdle(0, 400, "t2");
        checkFrame(0, "t2", 20, 1, 4, 164, 1, 0, 20, 64'h80001);
        checkOutput("t2_frameCnt", 64'(frameCnt0), 64'd1);
        checkOutput("t2_sdataHold", 64'(sdata0), 64'd1);
        checkOutput("t2_idleSclkLatch", {62'd0, sclk0, latch0}, 64'd0);

        // CLK_DIV=1, alternating pattern, 41-cycle frame.
        snap(1);
        applyStimulus(1, 20'hAAAAA);
        waitIdle(1, 200, "t3");
        checkFrame(1, "t3", 20, 1, 1, 41, 1, 0, 20, 64'hAAAAA);
        checkOutput("t3_frameCnt", 64'(frameCnt1), 64'd1);

        // Second frame queued during shift follows with no idle gap.
        snap(0);
        applyStimulus(0, 20'hF0F0F);
        repeat (30) @(posedge clk);
        applyStimulus(0, 20'h00001);
        waitIdle(0, 800, "t4");
        checkFrame(0, "t4", 40, 2, 8, 328, 1, 0, 40, 64'hF0F0F00001);
        checkOutput("t4_frameCnt", 64'(frameCnt0), 64'd3);

        // Three strobes during one frame: newest wins, two overruns.
        snap(0);
        applyStimulus(0, 20'h12345);
        repeat (10) @(posedge clk);
        applyStimulus(0, 20'h11111);
        repeat (10) @(posedge clk);
        applyStimulus(0, 20'h22222);
        repeat (10) @(posedge clk);
        applyStimulus(0, 20'h3C3C3);
        waitIdle(0, 800, "t5");
        checkFrame(0, "t5", 40, 2, 8, 328, 1, 2, 40, 64'h123453C3C3);
        checkOutput("t5_frameCnt", 64'(frameCnt0), 64'd5);

        // Reset in the middle of a frame.
        snap(0);
        applyStimulus(0, 20'hFFFFF);
        repeat (49) @(posedge clk);
        #1;
        rstN0 = 1'b0;
        #1;
        checkOutput("t6_outsZero", {59'd0, sclk0, sdata0, latch0, busy0, overrun0}, 64'd0);
        checkOutput("t6_frameCnt", 64'(frameCnt0), 64'd0);
        checkOutput("t6_noLatch", 64'(latchPulses0 - bLp), 64'd0);
        valid0 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_validInReset", 64'(busy0), 64'd0);
        valid0 = 1'b0;
        @(posedge clk);
        #1;
        rstN0 = 1'b1;
        @(posedge clk);
        #1;
        snap(0);
        applyStimulus(0, 20'hC0003);
        waitIdle(0, 400, "t6b");
        checkFrame(0, "t6b", 20, 1, 4, 164, 1, 0, 20, 64'hC0003);
        checkOutput("t6b_frameCnt", 64'(frameCnt0), 64'd1);

        // 256 back-to-back frames on dut1, each next one strobed on the last
        // latch cycle of the previous; the counter wraps back to 0.
        #1;
        rstN1 = 1'b0;
        @(posedge clk);
        #1;
        rstN1 = 1'b1;
        snap(1);
        lastCells = 20'h00005;
        applyStimulus(1, lastCells);
        for (int k = 1; k < 256; k++) begin
            lastCells = 20'(k * 37 + 5);
            strobeAtLatch(lastCells);
        end
        checkOutput("t7_frameCnt255", 64'(frameCnt1), 64'd255);
        waitIdle(1, 200, "t7");
        checkFrame(1, "t7", 5120, 256, 256, 10496, 1, 0, 20, {44'd0, lastCells});
        checkOutput("t7_frameCntWrap", 64'(frameCnt1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
